// File: rtl/tcon_timing_pattern_gen.sv
// Synthesizable tcon timing and test-pattern generator: vsync/hsync/de plus solid, ramp, bar or checker pixels.
// Optional frame CRC-16-CCITT on pix_out is enabled by defining TPG_CRC_EN.
module tcon_timing_pattern_gen #(
    parameter int DW            = 8,
    parameter int CH            = 3,
    parameter int WIDTH         = 1280,
    parameter int HEIGHT        = 800,
    parameter int HSYNC_WIDTH   = 1,
    parameter int H_BACK_PORCH  = 10,
    parameter int H_FRONT_PORCH = 10,
    parameter int VSYNC_WIDTH   = 1,
    parameter int V_BACK_PORCH  = 1,
    parameter int V_FRONT_PORCH = 1,
    parameter int RAMP_SHIFT    = 0,
    parameter int CHK_SHIFT     = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       reg_mode,
    input  logic [CH*DW-1:0] reg_solid,
    output logic             vsync,
    output logic             hsync,
    output logic             de,
    output logic [CH*DW-1:0] pix_out,
    output logic             frame_end,
    output logic             busy
`ifdef TPG_CRC_EN
    ,
    output logic [15:0]      crc_out,
    output logic             crc_valid
`endif
);

    localparam int PW      = CH * DW;
    localparam int H_TOTAL = HSYNC_WIDTH + H_BACK_PORCH + WIDTH + H_FRONT_PORCH;
    localparam int V_TOTAL = VSYNC_WIDTH + V_BACK_PORCH + HEIGHT + V_FRONT_PORCH;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int H_ACT   = HSYNC_WIDTH + H_BACK_PORCH;
    localparam int V_ACT   = VSYNC_WIDTH + V_BACK_PORCH;
    localparam int BAR_W   = WIDTH / 8;
    localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            h_last, v_last, frame_wrap;
    logic [1:0]      mode_s;
    logic [PW-1:0]   solid_s;
    logic            vsync_d, hsync_d, de_d, frame_end_d;
    logic [PW-1:0]   pix_d, pix_pat;
    logic [HW-1:0]   x_pos;
    logic [VW-1:0]   y_pos;
    logic [31:0]     x32, bar_k;
    logic [2:0]      bar_code;
    logic            chk_odd;

    assign h_last     = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last     = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_wrap = h_last && v_last;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Once started, a frame always runs to its end; en only decides whether another follows.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = frame_wrap ? IDLE : STOP;
            STOP:    if (en) state_d = RUN;
                     else if (frame_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_q == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_s  <= '0;
            solid_s <= '0;
        end else if (h_cnt == '0 && v_cnt == '0) begin
            mode_s  <= reg_mode;
            solid_s <= reg_solid;
        end
    end

    assign x_pos = h_cnt - HW'(H_ACT);
    assign y_pos = v_cnt - VW'(V_ACT);

    always_comb begin
        x32      = 32'(x_pos);
        bar_k    = x32 / 32'(BAR_DIV);
        bar_code = 3'(32'd7 - ((bar_k > 32'd7) ? 32'd7 : bar_k));
        chk_odd  = 1'((x32 ^ 32'(y_pos)) >> CHK_SHIFT);
        pix_pat  = '0;
        case (mode_s)
            2'd0: pix_pat = solid_s;
            2'd1: for (int c = 0; c < CH; c++) pix_pat[c*DW +: DW] = DW'(x32 >> RAMP_SHIFT);
            2'd2: for (int c = 0; c < CH; c++) pix_pat[c*DW +: DW] = bar_code[2 - (c % 3)] ? {DW{1'b1}} : '0;
            default: pix_pat = chk_odd ? '0 : {PW{1'b1}};
        endcase
    end

    always_comb begin
        vsync_d     = 1'b0;
        hsync_d     = 1'b0;
        de_d        = 1'b0;
        frame_end_d = 1'b0;
        pix_d       = '0;
        if (state_q != IDLE) begin
            hsync_d     = (h_cnt < HW'(HSYNC_WIDTH));
            vsync_d     = (v_cnt < VW'(VSYNC_WIDTH));
            de_d        = (h_cnt >= HW'(H_ACT)) && (h_cnt < HW'(H_ACT + WIDTH)) &&
                          (v_cnt >= VW'(V_ACT)) && (v_cnt < VW'(V_ACT + HEIGHT));
            frame_end_d = frame_wrap;
            if (de_d) pix_d = pix_pat;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync     <= 1'b0;
            hsync     <= 1'b0;
            de        <= 1'b0;
            frame_end <= 1'b0;
            pix_out   <= '0;
        end else begin
            vsync     <= vsync_d;
            hsync     <= hsync_d;
            de        <= de_d;
            frame_end <= frame_end_d;
            pix_out   <= pix_d;
        end
    end

`ifdef TPG_CRC_EN
    logic [15:0] crc_acc;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [PW-1:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = PW - 1; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // The accumulator follows the registered pixel stream, so it closes one cycle after frame_end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_acc   <= 16'hFFFF;
            crc_out   <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= frame_end;
            if (frame_end) begin
                crc_out <= crc_acc;
                crc_acc <= 16'hFFFF;
            end else if (state_q == IDLE) begin
                crc_acc <= 16'hFFFF;
            end else if (de) begin
                crc_acc <= crc16_step(crc_acc, pix_out);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcon_timing_pattern_gen.sv
// Randomised scoreboard bench for tcon_timing_pattern_gen: a frame-position reference model
// predicts every output cycle; directed checks cover start latency, stop, re-assert and async reset.
`timescale 1ns/1ps
module tb_tcon_timing_pattern_gen;
    localparam int DW = 8, CH = 3, PW = DW * CH;
    localparam int WIDTH = 16, HEIGHT = 4;
    localparam int HS = 1, HBP = 2, HFP = 2, VS = 1, VBP = 1, VFP = 1;
    localparam int RAMP_SHIFT = 0, CHK_SHIFT = 1;
    localparam int H_TOTAL = HS + HBP + WIDTH + HFP;
    localparam int V_TOTAL = VS + VBP + HEIGHT + VFP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic          vsync;
        logic          hsync;
        logic          de;
        logic          frame_end;
        logic          busy;
        logic [PW-1:0] pix;
        logic          crc_valid;
        logic [15:0]   crc;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    reg_mode = 2'd0;
    logic [PW-1:0] reg_solid = '0;
    logic          vsync, hsync, de, frame_end, busy;
    logic [PW-1:0] pix_out;
`ifdef TPG_CRC_EN
    logic [15:0]   crc_out;
    logic          crc_valid;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    tcon_timing_pattern_gen #(
        .DW(DW), .CH(CH), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .HSYNC_WIDTH(HS), .H_BACK_PORCH(HBP), .H_FRONT_PORCH(HFP),
        .VSYNC_WIDTH(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP),
        .RAMP_SHIFT(RAMP_SHIFT), .CHK_SHIFT(CHK_SHIFT)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .reg_mode(reg_mode), .reg_solid(reg_solid),
        .vsync(vsync), .hsync(hsync), .de(de), .pix_out(pix_out),
        .frame_end(frame_end), .busy(busy)
`ifdef TPG_CRC_EN
        , .crc_out(crc_out), .crc_valid(crc_valid)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [PW-1:0] exp_pix(input logic [1:0] m, input logic [PW-1:0] solid,
                                              input int x, input int y);
        logic [PW-1:0] p;
        int k, code;
        p = '0;
        case (m)
            2'd0: p = solid;
            2'd1: for (int c = 0; c < CH; c++) p[c*DW +: DW] = DW'((x >> RAMP_SHIFT) % 256);
            2'd2: begin
                k = x / (WIDTH / 8);
                if (k > 7) k = 7;
                code = 7 - k;
                for (int c = 0; c < CH; c++)
                    if (((code >> (2 - c % 3)) & 1) == 1) p[c*DW +: DW] = 8'hFF;
            end
            default: if ((((x >> CHK_SHIFT) ^ (y >> CHK_SHIFT)) & 1) == 0) p = {PW{1'b1}};
        endcase
        return p;
    endfunction

    // Byte-wise CRC-16-CCITT over one pixel, most significant byte first.
    function automatic logic [15:0] crc_pixel(input logic [15:0] crc, input logic [PW-1:0] p);
        logic [15:0] c;
        c = crc;
        for (int b = PW / 8 - 1; b >= 0; b--) begin
            c = c ^ {p[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // reference model: pos is the cycle index inside the running frame, -1 when idle
    int            m_pos = -1;
    logic [1:0]    m_mode = 2'd0;
    logic [PW-1:0] m_solid = '0;
    logic [15:0]   m_crc_run = 16'hFFFF;
    logic [15:0]   m_crc_hold = 16'h0000;
    logic [15:0]   m_crc_due_val = 16'h0000;
    logic          m_crc_due = 1'b0;

    always @(posedge clk) begin : model
        exp_t e;
        int h, v;
        e = '0;
        if (!rstn) begin
            m_pos = -1; m_mode = 2'd0; m_solid = '0;
            m_crc_run = 16'hFFFF; m_crc_hold = 16'h0000; m_crc_due = 1'b0;
        end else begin
            if (m_pos >= 0) begin
                h = m_pos % H_TOTAL;
                v = m_pos / H_TOTAL;
                e.hsync     = (h < HS);
                e.vsync     = (v < VS);
                e.de        = (h >= HS + HBP) && (h < HS + HBP + WIDTH) &&
                              (v >= VS + VBP) && (v < VS + VBP + HEIGHT);
                e.frame_end = (m_pos == FRAME - 1);
                if (e.de) begin
                    e.pix = exp_pix(m_mode, m_solid, h - HS - HBP, v - VS - VBP);
                    m_crc_run = crc_pixel(m_crc_run, e.pix);
                end
            end
            e.crc_valid = m_crc_due;
            if (m_crc_due) m_crc_hold = m_crc_due_val;
            e.crc = m_crc_hold;
            m_crc_due = 1'b0;
            if (e.frame_end) begin
                m_crc_due = 1'b1;
                m_crc_due_val = m_crc_run;
                m_crc_run = 16'hFFFF;
            end
            if (m_pos <= 0) begin
                m_mode  = reg_mode;
                m_solid = reg_solid;
            end
            if (m_pos < 0 || m_pos == FRAME - 1) m_pos = en ? 0 : -1;
            else m_pos++;
            e.busy = (m_pos >= 0);
        end
        exp_q.push_back(EW'(e));
    end

    // monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            check("sync_flags", 64'({vsync, hsync, de, frame_end, busy}),
                  64'({e.vsync, e.hsync, e.de, e.frame_end, e.busy}));
            check("pix_out", 64'(pix_out), 64'(e.pix));
`ifdef TPG_CRC_EN
            check("crc", 64'({crc_valid, crc_out}), 64'({e.crc_valid, e.crc}));
`endif
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_fe(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_end && n < 400);
        check(name, 64'(frame_end), 64'(1));
    endtask

    int t0;
    logic [15:0] crc_solid_exp;

    initial begin
        step(3);
        check("reset_outputs", 64'({vsync, hsync, de, frame_end, busy, pix_out}), 64'(0));
        rstn = 1'b1;
        step(2);

        // start latency and frame period
        reg_mode = 2'd1;
        en = 1'b1;
        @(posedge clk); #1;
        check("vsync_edge1", 64'(vsync), 64'(0));
        @(posedge clk); #1;
        check("vsync_edge2", 64'(vsync), 64'(1));
        wait_fe("fe_first");
        t0 = cyc;
        wait_fe("fe_second");
        check("frame_period", 64'(cyc - t0), 64'(FRAME));

        // every mode for full frames, with a random solid colour
        for (int m = 0; m < 4; m++) begin
            step(1);
            reg_mode  = 2'(m);
            reg_solid = PW'($urandom);
            step(2 * FRAME);
        end

        // random mode / colour changes mid-frame and random en drops
        for (int i = 0; i < 6 * FRAME; i++) begin
            step(1);
            if ($urandom_range(0, 99) < 3) reg_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 3) reg_solid = PW'($urandom);
            if (en && $urandom_range(0, 99) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        end

        // en low mid-frame: frame completes, then idle
        step(1);
        en = 1'b1;
        reg_mode = 2'd2;
        wait_fe("fe_pre_stop");
        step(40);
        en = 1'b0;
        @(posedge clk); #1;
        check("stop_busy", 64'(busy), 64'(1));
        wait_fe("fe_stop");
        @(posedge clk); #1;
        check("stop_idle", 64'({vsync, hsync, de, frame_end, busy, pix_out}), 64'(0));
        step(5);
        check("stop_hold", 64'(busy), 64'(0));

        // re-assert during STOP: the frame keeps its normal length
        en = 1'b1;
        reg_mode = 2'd3;
        wait_fe("fe_restart");
        t0 = cyc;
        step(30);
        en = 1'b0;
        step(15);
        en = 1'b1;
        wait_fe("fe_reassert");
        check("reassert_period", 64'(cyc - t0), 64'(FRAME));

`ifdef TPG_CRC_EN
        // two solid frames against a directly computed frame CRC
        step(1);
        reg_mode  = 2'd0;
        reg_solid = PW'($urandom);
        crc_solid_exp = 16'hFFFF;
        for (int i = 0; i < WIDTH * HEIGHT; i++) crc_solid_exp = crc_pixel(crc_solid_exp, reg_solid);
        wait_fe("fe_crc0");
        for (int f = 0; f < 2; f++) begin
            wait_fe("fe_crc");
            @(posedge clk); #1;
            check("crc_valid_solid", 64'(crc_valid), 64'(1));
            check("crc_solid", 64'(crc_out), 64'(crc_solid_exp));
        end
`endif

        // async reset mid-frame
        step(70);
        rstn = 1'b0;
        #1;
        check("async_reset", 64'({vsync, hsync, de, frame_end, busy, pix_out}), 64'(0));
        step(3);
        rstn = 1'b1;
        step(FRAME + 20);
        en = 1'b0;
        step(2 * FRAME);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
